// File: rtl/imem_loader.sv
// Byte-stream program loader: frames a count, 4*N little-endian data bytes and
// an XOR checksum, writing each completed word into the instruction memory.
module imem_loader #(
   parameter int MEM_SIZE    = 2048,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   output logic        o_rx_ready,
   output logic        o_imem_we,
   output logic [12:0] o_imem_addr,
   output logic [31:0] o_imem_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic        o_cpu_hold,
   output logic [11:0] o_words_loaded
);

   // Handshake: a byte moves on a rising edge where i_rx_valid and o_rx_ready are
   // both high; o_rx_ready stays high through a load so bytes may arrive every cycle.
   typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR} state_t;

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   state_t        state;
   logic          busy;
   logic [15:0]   n;
   logic [11:0]   w;
   logic [1:0]    k;
   logic [23:0]   part;
   logic [7:0]    csum;
   logic [TW-1:0] to_cnt;

   logic          xfer;
   logic [15:0]   n_full;
   logic          last_word;
   logic          timeout_hit;

   assign xfer        = i_rx_valid & busy;
   assign n_full      = {i_rx_data, n[7:0]};
   assign last_word   = (({4'd0, w} + 16'd1) == n);
   assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt == TW'(TIMEOUT_CYC - 1));

   assign o_rx_ready  = busy;
   assign o_busy      = busy;
   assign o_cpu_hold  = busy;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state          <= IDLE;
         busy           <= 1'b0;
         n              <= 16'd0;
         w              <= 12'd0;
         k              <= 2'd0;
         part           <= 24'd0;
         csum           <= 8'd0;
         to_cnt         <= '0;
         o_imem_we      <= 1'b0;
         o_imem_addr    <= 13'd0;
         o_imem_wdata   <= 32'd0;
         o_done         <= 1'b0;
         o_err          <= 1'b0;
         o_words_loaded <= 12'd0;
      end else begin
         o_imem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (i_start) begin
                  state          <= CNT_LO;
                  busy           <= 1'b1;
                  o_done         <= 1'b0;
                  o_err          <= 1'b0;
                  o_words_loaded <= 12'd0;
                  csum           <= 8'd0;
                  k              <= 2'd0;
                  w              <= 12'd0;
                  to_cnt         <= '0;
               end
            end
            default: begin
               if (xfer) begin
                  to_cnt <= '0;
                  case (state)
                     CNT_LO: begin
                        n[7:0] <= i_rx_data;
                        state  <= CNT_HI;
                     end
                     CNT_HI: begin
                        n[15:8] <= i_rx_data;
                        if (n_full == 16'd0 || n_full > 16'(MEM_SIZE)) begin
                           state <= ERR;
                           busy  <= 1'b0;
                           o_err <= 1'b1;
                        end else begin
                           state <= DATA;
                        end
                     end
                     DATA: begin
                        csum <= csum ^ i_rx_data;
                        k    <= k + 2'd1;
                        case (k)
                           2'd0: part[7:0]   <= i_rx_data;
                           2'd1: part[15:8]  <= i_rx_data;
                           2'd2: part[23:16] <= i_rx_data;
                           default: begin
                              o_imem_we      <= 1'b1;
                              o_imem_addr    <= {w[10:0], 2'b00};
                              o_imem_wdata   <= {i_rx_data, part};
                              o_words_loaded <= w + 12'd1;
                              w              <= w + 12'd1;
                              if (last_word) state <= CSUM;
                           end
                        endcase
                     end
                     CSUM: begin
                        busy <= 1'b0;
                        if (i_rx_data == csum) begin
                           state  <= DONE;
                           o_done <= 1'b1;
                        end else begin
                           state <= ERR;
                           o_err <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end else if (timeout_hit) begin
                  state <= ERR;
                  busy  <= 1'b0;
                  o_err <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
         endcase
      end
   end

endmodule
